mcl_cyc_queue: RTL and testbench
================================

Name: mcl_cyc_queue

Overview:
Parametrised successor to the single-request MCL cycle logic. It decodes the CRAM MEM field into an MBOX request type, and qualifies it against the VMA section range. Legal requests go into a QDEPTH-entry issue queue, which presents them to the MBOX over a valid/ack handshake, and the block counts accepted-but-incomplete cycles up to MAX_OUT. It also keeps a VMA-held snapshot of the last accepted request for diagnostic read-back. It sits between the CRAM/VMA datapath and the MBOX interface.

Parameters:
VA_WIDTH, 23, virtual address width (VMA bits 13:35).
SEC_BITS, 5, section field width, taken as the top SEC_BITS of the VA.
NSECT, 32, number of legal sections; a section number >= NSECT is an address error.
QDEPTH, 2, issue queue entries (power of two, >= 2).
MAX_OUT, 2, maximum accepted-but-incomplete MBOX cycles (>= 1).

Ports:
clk  in  1  EBOX clock (CLK.MCL).
RESET_n  in  1  asynchronous active-low reset.
MEM  in  4  CRAM MEM field [0:3].
MAGIC  in  4  CRAM MAGIC[0:3]: request flags for EA_CALC.
AD_FLAGS  in  5  {AR,ARX,PAUSE,WRITE,FETCH} from EDP.AD, used for AD_FUNC.
LOAD_VMA  in  1  strobe: issue the decoded MEM request this cycle.
VA  in  VA_WIDTH  address loaded with the request.
USER  in  1  user-mode context bit.
PHYS  in  1  physical reference; suppresses the section check.
MBOX_REQ  out  1  head entry valid toward MBOX.
MBOX_ACK  in  1  MBOX accepts the head entry.
MBOX_DONE  in  1  one outstanding cycle completes.
REQ_FLAGS  out  5  head entry {AR,ARX,PAUSE,WRITE,FETCH}.
REQ_VA  out  VA_WIDTH  head entry address.
REQ_USER  out  1  head entry user bit.
STALL  out  1  EBOX must hold: queue full.
VMA_ADR_ERR  out  1  sticky address-error flag.
HELD  out  6  {flags,user} of the last MBOX-accepted entry.
OUT_CNT  out  clog2(MAX_OUT+1)  outstanding cycle count.
IDLE  out  1  queue empty and OUT_CNT==0.

Behaviour:
- Reset (asynchronous, RESET_n low):
  - queue empty, pointers 0, OUT_CNT=0.
  - MBOX_REQ=0, REQ_FLAGS=0, REQ_VA=0, REQ_USER=0.
  - VMA_ADR_ERR=0, HELD=0, STALL=0, IDLE=1.
  - Any in-flight request is dropped.
- Decode, when MEM[0]=1 (flags listed as AR,ARX,PAUSE,WRITE,FETCH):
  - 0 AD_FUNC: flags = AD_FLAGS.
  - 1 EA_CALC: flags = {MAGIC,0}.
  - 2 LOAD_AR: 10000.
  - 3 LOAD_ARX: 01000.
  - 4 RW: 10010.
  - 5 RPW: 10110.
  - 6 WRITE: 00010.
  - 7 UNCOND_FETCH: 01001.
- Decode, when MEM[0]=0: no request.
- A decoded request whose flags are all zero enqueues nothing.
- Enqueue occurs when LOAD_VMA=1, the request is non-null, and the queue is not full (or the queue is full but a dequeue happens the same cycle).
- Address error: section = VA[VA_WIDTH-1 -: SEC_BITS], with PHYS=0 and section >= NSECT.
  - The request is not enqueued.
  - VMA_ADR_ERR is set on the next edge and stays set until reset.
  - A LOAD_VMA that is both illegal and would stall sets the error and drops the request.
- STALL (combinational) = queue full & LOAD_VMA & non-null & ~(MBOX_REQ & MBOX_ACK & OUT_CNT<MAX_OUT).
  - While STALL=1 the request is not enqueued; the EBOX re-presents it on a later cycle.
- MBOX_REQ = queue non-empty & OUT_CNT<MAX_OUT. REQ_* show the head entry whenever the queue is non-empty.
- Dequeue on MBOX_REQ & MBOX_ACK. HELD is updated on that same edge. MBOX_ACK while MBOX_REQ=0 is ignored.
- OUT_CNT:
  - +1 on dequeue, -1 on MBOX_DONE.
  - Both in the same cycle: unchanged.
  - MBOX_DONE at OUT_CNT=0 is ignored (no underflow).
- Latency:
  - A request enqueued into an empty queue raises MBOX_REQ on the cycle after the LOAD_VMA edge.
  - Back-to-back ACKs drain one entry per cycle.
- Pointers wrap modulo QDEPTH. Ordering is strictly FIFO.

Test Plan:
- Reset release, MEM=4'b1101 (RPW), VA=0x000100, LOAD_VMA for 1 cycle -> next cycle MBOX_REQ=1, REQ_FLAGS=10110, REQ_VA=0x000100; ACK -> HELD=101100, OUT_CNT=1; DONE -> OUT_CNT=0, IDLE=1.
- NSECT=8, VA section 9, PHYS=0, LOAD_VMA -> no MBOX_REQ, VMA_ADR_ERR=1 and sticky; same address with PHYS=1 -> enqueued normally.
- QDEPTH=2, ACK held low, 3 consecutive LOAD_VMA -> first two enqueued, STALL=1 on the third; ACK that cycle -> third enqueued and STALL=0; entries drain in FIFO order.
- MAX_OUT=2, ACK held high, DONE low -> two entries accepted, MBOX_REQ drops with OUT_CNT=2; one DONE -> third issued the next cycle.
- Simultaneous ACK+DONE at OUT_CNT=1 -> OUT_CNT stays 1; DONE at OUT_CNT=0 -> stays 0.
- RESET_n pulsed low mid-transfer with queue=2 and OUT_CNT=1 -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mcl_cyc_queue.sv
// MCL cycle queue: decodes the CRAM MEM field into an MBOX request,
// qualifies it against the VMA section range, buffers legal requests in a
// small FIFO and issues them to the MBOX over a valid/ack handshake while
// tracking accepted-but-incomplete MBOX cycles.
module mcl_cyc_queue #(
    parameter int unsigned VA_WIDTH = 23,
    parameter int unsigned SEC_BITS = 5,
    parameter int unsigned NSECT    = 32,
    parameter int unsigned QDEPTH   = 2,
    parameter int unsigned MAX_OUT  = 2
) (
    input  logic                               clk,
    input  logic                               RESET_n,
    input  logic [0:3]                         MEM,
    input  logic [0:3]                         MAGIC,
    input  logic [4:0]                         AD_FLAGS,
    input  logic                               LOAD_VMA,
    input  logic [VA_WIDTH-1:0]                VA,
    input  logic                               USER,
    input  logic                               PHYS,
    output logic                               MBOX_REQ,
    input  logic                               MBOX_ACK,
    input  logic                               MBOX_DONE,
    output logic [4:0]                         REQ_FLAGS,
    output logic [VA_WIDTH-1:0]                REQ_VA,
    output logic                               REQ_USER,
    output logic                               STALL,
    output logic                               VMA_ADR_ERR,
    output logic [5:0]                         HELD,
    output logic [$clog2(MAX_OUT+1)-1:0]       OUT_CNT,
    output logic                               IDLE
);

    localparam int unsigned PW  = $clog2(QDEPTH);
    localparam int unsigned QCW = $clog2(QDEPTH + 1);
    localparam int unsigned CW  = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [4:0]          flags;
        logic [VA_WIDTH-1:0] va;
        logic                user;
    } entry_t;

    entry_t              store_q [QDEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [QCW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]       out_q, out_d;
    logic                err_q, err_d;
    logic [5:0]          held_q, held_d;

    logic [4:0]          dec_flags;
    logic [SEC_BITS-1:0] section;
    logic                req_valid, adr_err, can_issue, empty, full;
    logic                enq, deq, done_eff;
    entry_t              head;

    // MEM field decode into {AR,ARX,PAUSE,WRITE,FETCH}; MEM[0]=0 means no request
    always_comb begin
        dec_flags = '0;
        if (MEM[0]) begin
            unique case (MEM[1:3])
                3'd0: dec_flags = AD_FLAGS;
                3'd1: dec_flags = {MAGIC, 1'b0};
                3'd2: dec_flags = 5'b10000;
                3'd3: dec_flags = 5'b01000;
                3'd4: dec_flags = 5'b10010;
                3'd5: dec_flags = 5'b10110;
                3'd6: dec_flags = 5'b00010;
                3'd7: dec_flags = 5'b01001;
                default: dec_flags = '0;
            endcase
        end
    end

    // Request qualification, handshake and next-state computation
    always_comb begin
        section   = VA[VA_WIDTH-1 -: SEC_BITS];
        req_valid = LOAD_VMA && (dec_flags != '0);
        adr_err   = !PHYS && (32'(section) >= NSECT);
        can_issue = 32'(out_q) < MAX_OUT;
        empty     = (cnt_q == '0);
        full      = (32'(cnt_q) == QDEPTH);
        head      = store_q[rd_ptr_q];
        deq       = !empty && can_issue && MBOX_ACK;
        // A full queue still accepts when the head leaves on the same edge.
        enq       = req_valid && !adr_err && (!full || deq);
        done_eff  = MBOX_DONE && (out_q != '0);

        wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;

        cnt_d = cnt_q;
        if (enq && !deq)      cnt_d = cnt_q + QCW'(1);
        else if (!enq && deq) cnt_d = cnt_q - QCW'(1);

        out_d = out_q;
        if (deq && !done_eff)      out_d = out_q + CW'(1);
        else if (!deq && done_eff) out_d = out_q - CW'(1);

        err_d  = err_q || (req_valid && adr_err);
        held_d = deq ? {head.flags, head.user} : held_q;
    end

    // State registers and queue storage
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int unsigned i = 0; i < QDEPTH; i++) store_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
            held_q   <= '0;
        end else begin
            if (enq) store_q[wr_ptr_q] <= '{flags: dec_flags, va: VA, user: USER};
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            err_q    <= err_d;
            held_q   <= held_d;
        end
    end

    // Output drive; head fields read as zero while the queue is empty
    always_comb begin
        MBOX_REQ    = !empty && can_issue;
        REQ_FLAGS   = empty ? '0 : head.flags;
        REQ_VA      = empty ? '0 : head.va;
        REQ_USER    = empty ? 1'b0 : head.user;
        STALL       = full && req_valid && !deq;
        VMA_ADR_ERR = err_q;
        HELD        = held_q;
        OUT_CNT     = out_q;
        IDLE        = empty && (out_q == '0);
    end

endmodule

// File: tb/tb_mcl_cyc_queue.sv
// Scoreboard bench for mcl_cyc_queue: a driver applies directed and random
// stimulus, predicts occupancy/outstanding/error behaviour with plain
// counters and pushes every expected issue into a queue; a monitor pops and
// compares whenever the DUT completes an MBOX handshake.
module tb_mcl_cyc_queue;

    localparam int VA_W = 23;
    localparam int SECB = 5;
    localparam int NSEC = 8;
    localparam int QDEP = 2;
    localparam int MOUT = 2;

    typedef struct packed {
        logic [4:0]      f;
        logic [VA_W-1:0] va;
        logic            u;
    } ent_t;

    logic            clk, RESET_n;
    logic [3:0]      MEM, MAGIC;
    logic [4:0]      AD_FLAGS;
    logic            LOAD_VMA, USER, PHYS, MBOX_ACK, MBOX_DONE;
    logic [VA_W-1:0] VA;
    logic            MBOX_REQ, REQ_USER, STALL, VMA_ADR_ERR, IDLE;
    logic [4:0]      REQ_FLAGS;
    logic [VA_W-1:0] REQ_VA;
    logic [5:0]      HELD;
    logic [1:0]      OUT_CNT;

    int checks = 0;
    int failures = 0;

    ent_t sb[$];
    int   m_cnt = 0, m_out = 0;
    bit   m_err = 0;
    bit   held_pending = 0;
    logic [5:0] held_exp = '0;

    mcl_cyc_queue #(
        .VA_WIDTH (VA_W),
        .SEC_BITS (SECB),
        .NSECT    (NSEC),
        .QDEPTH   (QDEP),
        .MAX_OUT  (MOUT)
    ) dut (
        .clk         (clk),
        .RESET_n     (RESET_n),
        .MEM         (MEM),
        .MAGIC       (MAGIC),
        .AD_FLAGS    (AD_FLAGS),
        .LOAD_VMA    (LOAD_VMA),
        .VA          (VA),
        .USER        (USER),
        .PHYS        (PHYS),
        .MBOX_REQ    (MBOX_REQ),
        .MBOX_ACK    (MBOX_ACK),
        .MBOX_DONE   (MBOX_DONE),
        .REQ_FLAGS   (REQ_FLAGS),
        .REQ_VA      (REQ_VA),
        .REQ_USER    (REQ_USER),
        .STALL       (STALL),
        .VMA_ADR_ERR (VMA_ADR_ERR),
        .HELD        (HELD),
        .OUT_CNT     (OUT_CNT),
        .IDLE        (IDLE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference request table: mem[3] is MEM[0], mem[2:0] the request code
    function automatic logic [4:0] ref_flags(input logic [3:0] mem, input logic [3:0] magic,
                                             input logic [4:0] adf);
        logic [4:0] tbl [8];
        tbl = '{5'b00000, 5'b00000, 5'b10000, 5'b01000, 5'b10010, 5'b10110, 5'b00010, 5'b01001};
        if (!mem[3]) return 5'b00000;
        if (mem[2:0] == 3'd0) return adf;
        if (mem[2:0] == 3'd1) return {magic, 1'b0};
        return tbl[mem[2:0]];
    endfunction

    // One clock: drive inputs, check combinational/registered outputs against the model, advance model
    task automatic step(input logic [3:0] mem, input logic [3:0] magic, input logic [4:0] adf,
                        input logic load, input logic [VA_W-1:0] va, input logic usr,
                        input logic phys, input logic ack, input logic done);
        logic [4:0] fl;
        bit adr, req, mreq, deq, full, stall, enq;
        @(negedge clk);
        MEM = mem; MAGIC = magic; AD_FLAGS = adf; LOAD_VMA = load; VA = va;
        USER = usr; PHYS = phys; MBOX_ACK = ack; MBOX_DONE = done;
        #1;
        fl    = ref_flags(mem, magic, adf);
        adr   = !phys && (int'(va[VA_W-1 -: SECB]) >= NSEC);
        req   = load && (fl != 5'b0);
        mreq  = (m_cnt > 0) && (m_out < MOUT);
        deq   = mreq && ack;
        full  = (m_cnt == QDEP);
        stall = full && req && !deq;
        enq   = req && !adr && (!full || deq);
        chk("MBOX_REQ", 32'(MBOX_REQ), 32'(mreq));
        chk("STALL", 32'(STALL), 32'(stall));
        chk("OUT_CNT", 32'(OUT_CNT), 32'(m_out));
        chk("IDLE", 32'(IDLE), 32'((m_cnt == 0) && (m_out == 0)));
        chk("VMA_ADR_ERR", 32'(VMA_ADR_ERR), 32'(m_err));
        if (m_cnt == 0) chk("REQ_FLAGS_empty", 32'(REQ_FLAGS), 32'd0);
        if (enq) sb.push_back('{f: fl, va: va, u: usr});
        m_cnt = m_cnt + int'(enq) - int'(deq);
        m_out = m_out + int'(deq) - int'(done && (m_out > 0));
        m_err = m_err || (req && adr);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_MBOX_REQ"}, 32'(MBOX_REQ), 32'd0);
        chk({tag, "_REQ_FLAGS"}, 32'(REQ_FLAGS), 32'd0);
        chk({tag, "_REQ_VA"}, 32'(REQ_VA), 32'd0);
        chk({tag, "_REQ_USER"}, 32'(REQ_USER), 32'd0);
        chk({tag, "_STALL"}, 32'(STALL), 32'd0);
        chk({tag, "_ERR"}, 32'(VMA_ADR_ERR), 32'd0);
        chk({tag, "_HELD"}, 32'(HELD), 32'd0);
        chk({tag, "_OUT_CNT"}, 32'(OUT_CNT), 32'd0);
        chk({tag, "_IDLE"}, 32'(IDLE), 32'd1);
    endtask

    // Monitor: every completed handshake must match the oldest expected entry
    always @(negedge clk) begin
        ent_t e;
        #2;
        if (held_pending) begin
            chk("HELD", 32'(HELD), 32'(held_exp));
            held_pending = 0;
        end
        if (RESET_n && MBOX_REQ && MBOX_ACK) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: DUT issued flags=%0h va=%0h with nothing expected at t=%0t",
                         REQ_FLAGS, REQ_VA, $time);
            end else begin
                e = sb.pop_front();
                chk("REQ_FLAGS", 32'(REQ_FLAGS), 32'(e.f));
                chk("REQ_VA", 32'(REQ_VA), 32'(e.va));
                chk("REQ_USER", 32'(REQ_USER), 32'(e.u));
                held_exp = {e.f, e.u};
                held_pending = 1;
            end
        end
    end

    localparam logic [3:0] RPW   = 4'b1101;
    localparam logic [3:0] LDAR  = 4'b1010;
    localparam logic [3:0] LDARX = 4'b1011;
    localparam logic [3:0] WR    = 4'b1110;
    localparam logic [3:0] RW    = 4'b1100;
    localparam logic [3:0] NOP   = 4'b0000;
    localparam logic [VA_W-1:0] VA0  = 23'h000100;
    localparam logic [VA_W-1:0] VA9  = 23'h240100;

    initial begin
        RESET_n = 1'b0;
        MEM = '0; MAGIC = '0; AD_FLAGS = '0; LOAD_VMA = 0; VA = '0;
        USER = 0; PHYS = 0; MBOX_ACK = 0; MBOX_DONE = 0;
        #3;
        check_reset_outputs("por");
        #9 RESET_n = 1'b1;

        // single RPW round trip
        step(RPW, 4'h0, 5'h00, 1, VA0, 0, 0, 0, 0);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 0, 0);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 1, 0);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 0, 0);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 0, 1);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 0, 0);

        // out-of-range section, then the same address as a physical reference
        step(RW,  4'h0, 5'h00, 1, VA9, 1, 0, 0, 0);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 0, 0);
        step(RW,  4'h0, 5'h00, 1, VA9, 1, 1, 0, 0);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 1, 0);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 0, 1);

        // fill, stall, then ACK relieves the stall in the same cycle
        step(LDAR,  4'h0, 5'h00, 1, 23'h000011, 0, 0, 0, 0);
        step(LDARX, 4'h0, 5'h00, 1, 23'h000022, 1, 0, 0, 0);
        step(WR,    4'h0, 5'h00, 1, 23'h000033, 0, 0, 0, 0);
        step(WR,    4'h0, 5'h00, 1, 23'h000033, 0, 0, 1, 0);
        step(NOP,   4'h0, 5'h00, 0, VA0, 0, 0, 1, 0);
        // OUT_CNT saturates at MAX_OUT, DONE frees a slot
        step(NOP,   4'h0, 5'h00, 0, VA0, 0, 0, 1, 0);
        step(NOP,   4'h0, 5'h00, 0, VA0, 0, 0, 1, 1);
        step(NOP,   4'h0, 5'h00, 0, VA0, 0, 0, 1, 1);
        // AD_FUNC, EA_CALC, and simultaneous ACK+DONE
        step(4'b1000, 4'h0, 5'b00101, 1, 23'h000044, 1, 0, 0, 1);
        step(4'b1001, 4'hA, 5'b00000, 1, 23'h000055, 0, 0, 1, 0);
        step(NOP,   4'h0, 5'h00, 0, VA0, 0, 0, 1, 1);
        step(4'b1000, 4'h0, 5'b00000, 1, 23'h000066, 0, 0, 0, 1);
        repeat (4) step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] rm;
            logic [VA_W-1:0] rv;
            rm = {1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7))};
            rv = {5'($urandom_range(0, 9)), 18'($urandom)};
            step(rm, 4'($urandom), 5'($urandom), 1'($urandom_range(0, 9) < 7), rv,
                 1'($urandom), 1'($urandom_range(0, 4) == 0),
                 1'($urandom), 1'($urandom_range(0, 9) < 4));
        end

        // drain, then build queue=2 / OUT_CNT=1 and reset mid-transfer
        repeat (8) step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 1, 1);
        repeat (3) step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 0, 1);
        step(RW,    4'h0, 5'h00, 1, 23'h000077, 0, 0, 0, 0);
        step(NOP,   4'h0, 5'h00, 0, VA0, 0, 0, 1, 0);
        step(LDAR,  4'h0, 5'h00, 1, 23'h000088, 1, 0, 0, 0);
        step(LDARX, 4'h0, 5'h00, 1, 23'h000099, 0, 0, 0, 0);
        step(WR,    4'h0, 5'h00, 1, 23'h0000AA, 0, 0, 0, 0);
        #2 RESET_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb.delete();
        m_cnt = 0; m_out = 0; m_err = 0;
        held_pending = 0;
        @(negedge clk);
        MBOX_ACK = 0; LOAD_VMA = 0;
        #3 RESET_n = 1'b1;
        step(RPW, 4'h0, 5'h00, 1, VA0, 1, 0, 0, 0);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 1, 0);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 0, 1);
        step(NOP, 4'h0, 5'h00, 0, VA0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
